// File: rtl/rr_arb4_if.sv
// Requester/arbiter bus for rr_arb4: request and data lines in, grant, mux select
// and the registered mux output with its qualifier out.
interface rr_arb4_if;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    logic       y_vld;

    modport master (
        output req, d,
        input  gnt, sel, busy, y, y_vld
    );

    modport slave (
        input  req, d,
        output gnt, sel, busy, y, y_vld
    );
endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with per-owner hold limit and a registered 4:1 data mux.
// Optional macro RR_ARB4_LOCK_EN adds a lock input that lets the owner exceed HOLD_MAX.
module rr_arb4 #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
`ifdef RR_ARB4_LOCK_EN
    input  logic       lock,
`endif
    rr_arb4_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [3:0] HMAX_M1 = 4'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] hcnt_q, hcnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       y_q, y_d;
    logic       y_vld_q, y_vld_d;

    logic       lock_hold;
    logic       hit_max;
    logic       new_grant;
    logic [1:0] owner;

    // First set request bit scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       hit;
        pick = start;
        hit  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!hit && r[idx]) begin
                pick = idx;
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef RR_ARB4_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign hit_max = (hcnt_q == HMAX_M1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        y_d       = busy_q ? bus.d[sel_q] : y_q;
        y_vld_d   = busy_q;
        new_grant = 1'b0;
        owner     = sel_q;

        case (state_q)
            IDLE: begin
                gnt_d  = 4'b0000;
                busy_d = 1'b0;
                if (|bus.req) begin
                    new_grant = 1'b1;
                    owner     = rr_pick(bus.req, ptr_q);
                end
            end
            GRANT: begin
                if (bus.req[sel_q] && (!hit_max || lock_hold)) begin
                    // Under lock the counter parks at its limit so release is immediate once lock drops.
                    hcnt_d = hit_max ? hcnt_q : hcnt_q + 4'd1;
                end else if (|bus.req) begin
                    new_grant = 1'b1;
                    owner     = rr_pick(bus.req, sel_q + 2'd1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase

        if (new_grant) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << owner;
            sel_d   = owner;
            busy_d  = 1'b1;
            hcnt_d  = 4'd0;
            ptr_d   = owner + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            hcnt_q  <= 4'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            y_q     <= 1'b0;
            y_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.y     = y_q;
    assign bus.y_vld = y_vld_q;

endmodule
